// File: rtl/calc_crc32.sv
// rtl/calc_crc32.sv - byte-serial Ethernet CRC-32 (reflected 0xEDB88320) FCS engine
// Register is re-seeded on reset or between frames; output is its complement.
module calc_crc32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_calc,
  input  logic        i_vl,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc32
);

  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_SEED = 32'hFFFFFFFF;

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  // Unrolled at elaboration into a pure XOR network, one byte per cycle.
  function automatic logic [31:0] next_crc(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in ^ {24'h0, d};
    for (int b = 0; b < 8; b++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  always_comb begin
    crc_d = crc_q;
    if (!i_vl) begin
      crc_d = CRC_SEED;
    end else if (i_calc) begin
      crc_d = next_crc(crc_q, i_data);
    end
  end

  // rst_n is active-high despite its name.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      crc_q <= CRC_SEED;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign o_crc32 = ~crc_q;

endmodule

// File: tb/tb_calc_crc32.sv
// tb/tb_calc_crc32.sv - self-checking bench for calc_crc32
module tb_calc_crc32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_calc;
  logic        i_vl;
  logic [7:0]  i_data;
  logic [31:0] o_crc32;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        rst;
    logic        vl;
    logic        calc;
    logic [7:0]  data;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] model_q[$];

  calc_crc32 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_calc  (i_calc),
    .i_vl    (i_vl),
    .i_data  (i_data),
    .o_crc32 (o_crc32)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] exp);
    n_total++;
    if (o_crc32 === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, o_crc32, exp);
  endtask

  task automatic step(input logic rst, input logic vl, input logic calc, input logic [7:0] d);
    rst_n  = rst;
    i_vl   = vl;
    i_calc = calc;
    i_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic rst, input logic vl, input logic calc, input logic [7:0] d,
                     input logic chk, input logic [31:0] exp);
    vec_t v;
    v.rst = rst; v.vl = vl; v.calc = calc; v.data = d; v.chk = chk; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic add_check_string();
    for (int i = 0; i < 9; i++) add(1'b0, 1'b1, 1'b1, 8'h31 + 8'(i), i == 8, 32'hCBF43926);
  endtask

  // Reference FCS: CRC of every byte accepted since the last seed, from scratch.
  function automatic logic [31:0] ref_fcs(input logic [7:0] q[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c = c ^ {24'h0, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  initial begin
    rst_n = 1'b1; i_vl = 1'b1; i_calc = 1'b1; i_data = 8'h00;

    add(1'b1, 1'b1, 1'b1, 8'($urandom), 1'b1, 32'h0);
    add(1'b1, 1'b1, 1'b1, 8'($urandom), 1'b1, 32'h0);
    add_check_string();
    for (int i = 0; i < 5; i++) add(1'b0, 1'b1, 1'b0, 8'($urandom), 1'b1, 32'hCBF43926);
    add(1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 32'h0);
    add_check_string();
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 32'h0);
    add(1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 32'hD202EF8D);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 32'h0);
    add(1'b0, 1'b1, 1'b1, 8'h61, 1'b1, 32'hE8B7BE43);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 32'h0);
    add_check_string();
    add(1'b0, 1'b1, 1'b1, 8'h26, 1'b0, 32'h0);
    add(1'b0, 1'b1, 1'b1, 8'h39, 1'b0, 32'h0);
    add(1'b0, 1'b1, 1'b1, 8'hF4, 1'b0, 32'h0);
    add(1'b0, 1'b1, 1'b1, 8'hCB, 1'b1, 32'h2144DF1C);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].vl, vecs[i].calc, vecs[i].data);
      if (vecs[i].chk) check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Gapped enable with garbage on the skipped cycles
    step(1'b0, 1'b0, 1'b1, 8'hA5);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b1, 1'b1, 8'h31 + 8'(i));
      step(1'b0, 1'b1, 1'b0, 8'($urandom));
    end
    check("gapped", 32'hCBF43926);

    // Reset mid-string discards the partial CRC
    step(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 8'h31 + 8'(i));
    step(1'b1, 1'b1, 1'b1, 8'($urandom));
    check("rst_mid", 32'h0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b1, 8'h31 + 8'(i));
    check("after_rst", 32'hCBF43926);

    // i_vl low mid-string dominates i_calc
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 8'h31 + 8'(i));
    step(1'b0, 1'b0, 1'b1, 8'hFF);
    check("vl_mid", 32'h0);

    // Randomized traffic against the reference model
    step(1'b0, 1'b0, 1'b0, 8'h00);
    model_q.delete();
    for (int n = 0; n < 2000; n++) begin
      logic       r_rst, r_vl, r_calc;
      logic [7:0] r_d;
      r_rst  = ($urandom % 64) == 0;
      r_vl   = ($urandom % 16) != 0;
      r_calc = ($urandom % 4) != 0;
      r_d    = 8'($urandom);
      step(r_rst, r_vl, r_calc, r_d);
      if (r_rst || !r_vl) model_q.delete();
      else if (r_calc) model_q.push_back(r_d);
      check($sformatf("rand%0d", n), ref_fcs(model_q));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
